// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Front-end fetch stage. Holds the PC and issues sequential word reads on
//   port A of the instruction SRAM. It absorbs the one-cycle SRAM read latency
//   and back-pressure from decode in a small response buffer, and presents
//   {pc, instr} to decode over a valid/ready handshake. A redirect from execute
//   (branch/jump/trap) flushes everything and restarts fetch at a new PC.
//
// Parameters
//   INSTR_ADDR_WIDTH  SRAM word-address width
//   BOOT_ADDR         byte PC loaded at reset (bits [1:0] ignored)
//   FIFO_DEPTH        response buffer entries (>= 2 for full throughput)
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   mem_addr        out  SRAM word address, always pc_q[INSTR_ADDR_WIDTH+1:2]
//   mem_req         out  a read is issued this cycle
//   mem_rdata       in   SRAM read data, valid the cycle after the issue
//   redirect_valid  in   restart fetch at redirect_pc
//   redirect_pc     in   new byte PC (bits [1:0] forced to 0)
//   fetch_valid     out  fetch_pc/fetch_instr valid
//   fetch_ready     in   decode accepts when fetch_valid && fetch_ready
//   fetch_instr     out  instruction word at the buffer head
//   fetch_pc        out  byte address of fetch_instr
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned INSTR_ADDR_WIDTH = 12,
  parameter logic [31:0] BOOT_ADDR        = 32'h0,
  parameter int unsigned FIFO_DEPTH       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [INSTR_ADDR_WIDTH-1:0] mem_addr,
  output logic                        mem_req,
  input  logic [31:0]                 mem_rdata,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        fetch_valid,
  input  logic                        fetch_ready,
  output logic [31:0]                 fetch_instr,
  output logic [31:0]                 fetch_pc
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      BOOT_PC_C = BOOT_ADDR & ~32'h3;

  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      buf_pc_q    [FIFO_DEPTH];
  logic [31:0]      buf_instr_q [FIFO_DEPTH];

  logic             pop;
  logic             push;
  logic [CNT_W:0]   occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Buffer head drives decode directly from registers.
  assign fetch_valid = (count_q != '0);
  assign fetch_pc    = buf_pc_q[rd_ptr_q];
  assign fetch_instr = buf_instr_q[rd_ptr_q];

  assign mem_addr = pc_q[INSTR_ADDR_WIDTH+1:2];

  assign pop  = fetch_valid && fetch_ready;
  assign push = inflight_q;

  // Entries that will be held once everything already committed lands,
  // minus the one decode takes this cycle. A pop implies count_q >= 1,
  // so this never underflows.
  assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);

  // Reset holds the request low so nothing looks issued while in reset.
  assign mem_req = !rst && !redirect_valid && (occupancy < {1'b0, DEPTH_C});

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (redirect_valid) begin
      // Flush: buffered entries and the in-flight response are dropped.
      pc_d     = redirect_pc & ~32'h3;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (mem_req) begin
        pc_d          = pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---- issue stage / buffer control registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= BOOT_PC_C;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // ---- response stage: capture SRAM data one cycle after issue ----
  // Entries are cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
      end
    end else if (push && !redirect_valid) begin
      buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
      buf_instr_q[wr_ptr_q] <= mem_rdata;
    end
  end

`ifndef SYNTHESIS
  // Issue throttling keeps the buffer from ever overflowing.
  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit with a registered-read SRAM model
//   holding word k = 0xA000_0000 + k. Inputs change 1 time unit after the
//   rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int hs_base = 0;

  logic [31:0] mem [4096];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .INSTR_ADDR_WIDTH(12),
    .BOOT_ADDR       (32'h0),
    .FIFO_DEPTH      (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_req       (mem_req),
    .mem_rdata     (mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_instr   (fetch_instr),
    .fetch_pc      (fetch_pc)
  );

  // Synchronous-read SRAM port A model.
  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = 32'hA000_0000 + 32'(k);
  end
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  // Count decode handshakes.
  always @(negedge clk) begin
    if (!rst && fetch_valid && fetch_ready) hs_cnt = hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, ".valid"}, 32'(fetch_valid), 32'd1);
    check({tag, ".pc"}, fetch_pc, pc);
    check({tag, ".instr"}, fetch_instr, instr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    fetch_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    sample();
    check("rst.valid", 32'(fetch_valid), 32'd0);
    check("rst.req",   32'(mem_req),     32'd0);
    check("rst.pc",    fetch_pc,         32'h0);
    check("rst.instr", fetch_instr,      32'h0);
    check("rst.addr",  32'(mem_addr),    32'h0);

    // 1: streaming from BOOT_ADDR
    drive_edge(); rst = 1'b0; sample();            // C0
    check("t1.c0.req",   32'(mem_req),     32'd1);
    check("t1.c0.addr",  32'(mem_addr),    32'h0);
    check("t1.c0.valid", 32'(fetch_valid), 32'd0);
    drive_edge(); sample();                        // C1
    check("t1.c1.valid", 32'(fetch_valid), 32'd0);
    check("t1.c1.addr",  32'(mem_addr),    32'h1);
    for (int k = 0; k < 6; k++) begin              // C2..C7
      drive_edge(); sample();
      check_out("t1.stream", 32'(4 * k), 32'hA000_0000 + 32'(k));
    end

    // 2: back-pressure for 5 cycles
    for (int i = 0; i < 5; i++) begin              // C8..C12
      drive_edge(); fetch_ready = 1'b0; sample();
      check_out("t2.hold", 32'd24, 32'hA000_0006);
      check("t2.hold.req", 32'(mem_req), 32'd0);
    end
    drive_edge(); fetch_ready = 1'b1; sample();    // C13
    check_out("t2.release", 32'd24, 32'hA000_0006);
    check("t2.release.req", 32'(mem_req), 32'd1);
    for (int k = 7; k < 11; k++) begin             // C14..C17
      drive_edge(); sample();
      check_out("t2.resume", 32'(4 * k), 32'hA000_0000 + 32'(k));
    end

    // 3: redirect with one entry buffered and one read in flight, no handshake
    drive_edge(); redirect_valid = 1'b1; redirect_pc = 32'h103; fetch_ready = 1'b0; sample(); // C18
    check("t3.redir.req", 32'(mem_req), 32'd0);
    check_out("t3.redir", 32'd44, 32'hA000_000B);
    drive_edge(); redirect_valid = 1'b0; fetch_ready = 1'b1; sample(); // C19
    check("t3.c19.valid", 32'(fetch_valid), 32'd0);
    check("t3.c19.req",   32'(mem_req),     32'd1);
    check("t3.c19.addr",  32'(mem_addr),    32'h40);
    drive_edge(); sample();                        // C20
    check("t3.c20.valid", 32'(fetch_valid), 32'd0);
    check("t3.c20.addr",  32'(mem_addr),    32'h41);
    drive_edge(); hs_base = hs_cnt; sample();      // C21
    check_out("t3.new0", 32'h100, 32'hA000_0040);
    drive_edge(); sample();                        // C22
    check_out("t3.new1", 32'h104, 32'hA000_0041);

    // 4: redirect in the same cycle as a decode handshake
    drive_edge(); redirect_valid = 1'b1; redirect_pc = 32'h200; sample(); // C23
    check_out("t4.hs", 32'h108, 32'hA000_0042);
    check("t4.redir.req", 32'(mem_req), 32'd0);
    drive_edge(); redirect_valid = 1'b0; sample(); // C24
    check("t4.c24.valid", 32'(fetch_valid), 32'd0);
    check("t4.c24.addr",  32'(mem_addr),    32'h80);
    drive_edge(); sample();                        // C25
    check("t4.c25.valid", 32'(fetch_valid), 32'd0);
    drive_edge(); sample();                        // C26
    check_out("t4.new0", 32'h200, 32'hA000_0080);
    drive_edge(); sample();                        // C27
    check_out("t4.new1", 32'h204, 32'hA000_0081);

    // 5: address wrap of the SRAM word address
    drive_edge();                                  // C28
    check("t4.hs_count", 32'(hs_cnt - hs_base), 32'd5);
    redirect_valid = 1'b1; redirect_pc = 32'h3FF8; sample();
    check("t5.redir.req", 32'(mem_req), 32'd0);
    drive_edge(); redirect_valid = 1'b0; sample(); // C29
    check("t5.c29.addr", 32'(mem_addr), 32'hFFE);
    drive_edge(); sample();                        // C30
    check("t5.c30.addr", 32'(mem_addr), 32'hFFF);
    drive_edge(); sample();                        // C31
    check_out("t5.w4094", 32'h3FF8, 32'hA000_0FFE);
    check("t5.c31.addr", 32'(mem_addr), 32'h000);
    drive_edge(); sample();                        // C32
    check_out("t5.w4095", 32'h3FFC, 32'hA000_0FFF);
    drive_edge(); sample();                        // C33
    check_out("t5.w0", 32'h4000, 32'hA000_0000);

    // 6: reset while the buffer is full and decode stalls
    drive_edge(); fetch_ready = 1'b0; sample();    // C34
    check_out("t6.c34", 32'h4004, 32'hA000_0001);
    check("t6.c34.req", 32'(mem_req), 32'd0);
    drive_edge(); sample();                        // C35
    check_out("t6.full", 32'h4004, 32'hA000_0001);
    #2; rst = 1'b1; #1;
    check("t6.async.valid", 32'(fetch_valid), 32'd0);
    check("t6.async.req",   32'(mem_req),     32'd0);
    check("t6.async.pc",    fetch_pc,         32'h0);
    check("t6.async.instr", fetch_instr,      32'h0);
    check("t6.async.addr",  32'(mem_addr),    32'h0);
    drive_edge();
    drive_edge(); rst = 1'b0; fetch_ready = 1'b1; sample(); // C0'
    check("t6.c0.req",   32'(mem_req),     32'd1);
    check("t6.c0.valid", 32'(fetch_valid), 32'd0);
    drive_edge(); sample();                        // C1'
    check("t6.c1.valid", 32'(fetch_valid), 32'd0);
    drive_edge(); sample();                        // C2'
    check_out("t6.boot0", 32'h0, 32'hA000_0000);
    drive_edge(); sample();                        // C3'
    check_out("t6.boot1", 32'h4, 32'hA000_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
